// File: rtl/escaner_display.sv
// -----------------------------------------------------------------------------
// escaner_display
//   Time-multiplexed scanner for a four-digit common-anode seven-segment
//   display. One nibble of the displayed value is presented per scan slot to a
//   single downstream hex-to-segment decoder, together with the matching
//   active-low anode. New values are latched as "pending" and only become the
//   displayed value at a frame boundary, so one frame never mixes two values.
//
// Parameters
//   DIVISOR       clock cycles per digit slot (2 .. 2^20)
//   BLANCO_CEROS  1 = blank leading zeros, 0 = always show all four digits
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   valor[15:0]    value to display, [3:0] is digit 0 (rightmost)
//   cargar         load strobe, valor sampled on every cycle it is high
//   numeroMostrar  nibble for the downstream decoder (registered)
//   anodos         active-low digit enables, bit i = digit i (registered)
//   actualizado    one-cycle pulse when a new value becomes the displayed one
// -----------------------------------------------------------------------------
module escaner_display #(
   parameter int unsigned DIVISOR      = 50000,
   parameter int unsigned BLANCO_CEROS = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] valor,
   input  logic        cargar,
   output logic [3:0]  numeroMostrar,
   output logic [3:0]  anodos,
   output logic        actualizado
);

   localparam int unsigned CW = $clog2(DIVISOR);
   localparam logic [CW-1:0] CMAX = CW'(DIVISOR - 1);

   logic [CW-1:0] contador_q, contador_d;
   logic [1:0]    indice_q, indice_d;
   logic [15:0]   activo_q, activo_d;
   logic [15:0]   pendiente_q, pendiente_d;
   logic          bandera_q, bandera_d;
   logic [3:0]    num_q, num_d;
   logic [3:0]    an_q, an_d;
   logic          act_q, act_d;

   logic          tick;
   logic          frontera;
   logic          blanco;

   assign tick     = (contador_q == CMAX);
   assign frontera = tick && (indice_q == 2'd3);

   always_comb begin
      contador_d  = tick ? '0 : contador_q + 1'b1;
      indice_d    = tick ? indice_q + 2'd1 : indice_q;

      // Last load in a frame wins; a load on the boundary cycle itself is
      // applied immediately, so nothing is left pending afterwards.
      pendiente_d = cargar ? valor : pendiente_q;
      bandera_d   = frontera ? 1'b0 : (bandera_q | cargar);

      activo_d    = activo_q;
      act_d       = 1'b0;
      if (frontera) begin
         if (cargar) begin
            activo_d = valor;
            act_d    = 1'b1;
         end else if (bandera_q) begin
            activo_d = pendiente_q;
            act_d    = 1'b1;
         end
      end

      // Outputs are derived from the next-state slot and value so that the
      // registered nibble/anode always match the slot and value just entered.
      blanco = 1'b0;
      if (BLANCO_CEROS != 0) begin
         case (indice_d)
            2'd1:    blanco = (activo_d[15:4]  == 12'h000);
            2'd2:    blanco = (activo_d[15:8]  == 8'h00);
            2'd3:    blanco = (activo_d[15:12] == 4'h0);
            default: blanco = 1'b0;
         endcase
      end

      if (blanco) begin
         num_d = 4'h0;
         an_d  = 4'b1111;
      end else begin
         num_d = activo_d[{indice_d, 2'b00} +: 4];
         an_d  = ~(4'b0001 << indice_d);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         contador_q  <= '0;
         indice_q    <= 2'd0;
         activo_q    <= 16'h0000;
         pendiente_q <= 16'h0000;
         bandera_q   <= 1'b0;
         num_q       <= 4'h0;
         an_q        <= 4'b1110;
         act_q       <= 1'b0;
      end else begin
         contador_q  <= contador_d;
         indice_q    <= indice_d;
         activo_q    <= activo_d;
         pendiente_q <= pendiente_d;
         bandera_q   <= bandera_d;
         num_q       <= num_d;
         an_q        <= an_d;
         act_q       <= act_d;
      end
   end

   assign numeroMostrar = num_q;
   assign anodos        = an_q;
   assign actualizado   = act_q;

endmodule

// File: tb/tb_escaner_display.sv
// -----------------------------------------------------------------------------
// tb_escaner_display
//   Directed bench for escaner_display with DIVISOR=4. Two instances share
//   the inputs: u_dut blanks leading zeros, u_nb shows all digits.
//   Edges are numbered from 1 after reset release; inputs are changed and
//   outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_escaner_display;

   logic        clk;
   logic        rst;
   logic [15:0] valor;
   logic        cargar;
   logic [3:0]  num_b, an_b, num_n, an_n;
   logic        act_b, act_n;

   int checks;
   int errors;
   int e;

   escaner_display #(.DIVISOR(4), .BLANCO_CEROS(1)) u_dut (
      .clk(clk), .rst(rst), .valor(valor), .cargar(cargar),
      .numeroMostrar(num_b), .anodos(an_b), .actualizado(act_b)
   );

   escaner_display #(.DIVISOR(4), .BLANCO_CEROS(0)) u_nb (
      .clk(clk), .rst(rst), .valor(valor), .cargar(cargar),
      .numeroMostrar(num_n), .anodos(an_n), .actualizado(act_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s edge %0d got %h exp %h", tag, e, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      e++;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      cargar = 1'b0;
      valor  = 16'h0000;
      step();
      rst = 1'b0;
      e   = 0;
   endtask

   // Hand-written expected tables for 0x0050 per slot
   logic [3:0] t3_num   [4] = '{4'h0, 4'h5, 4'h0, 4'h0};
   logic [3:0] t3_an_b  [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
   logic [3:0] t3_an_n  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   // 0x1234 per slot
   logic [3:0] t2_num   [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
   logic [3:0] t2_an    [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   initial begin
      int slot;
      int pulses;
      checks = 0;
      errors = 0;
      e      = 0;
      rst    = 1'b1;
      cargar = 1'b0;
      valor  = 16'h0000;

      // 1. reset state and idle scan with blanking
      do_reset();
      chk("rst_an",  32'(an_b),  32'h0000000E);
      chk("rst_num", 32'(num_b), 32'h0);
      chk("rst_act", 32'(act_b), 32'h0);
      for (int k = 1; k <= 32; k++) begin
         step();
         slot = (e / 4) % 4;
         chk("idle_an",  32'(an_b),  (slot == 0) ? 32'hE : 32'hF);
         chk("idle_num", 32'(num_b), 32'h0);
         chk("idle_act", 32'(act_b), 32'h0);
      end

      // 2. load 0x1234 at edge 2, displayed from edge 16
      do_reset();
      for (int k = 1; k <= 47; k++) begin
         if (e == 1) begin cargar = 1'b1; valor = 16'h1234; end
         step();
         cargar = 1'b0;
         chk("t2_act", 32'(act_b), (e == 16) ? 32'h1 : 32'h0);
         if (e >= 16 && (e % 4) == 0) begin
            slot = (e / 4) % 4;
            chk("t2_num", 32'(num_b), 32'(t2_num[slot]));
            chk("t2_an",  32'(an_b),  32'(t2_an[slot]));
         end
      end

      // 3. 0x0050 with and without blanking
      do_reset();
      for (int k = 1; k <= 35; k++) begin
         if (e == 0) begin cargar = 1'b1; valor = 16'h0050; end
         step();
         cargar = 1'b0;
         if (e >= 16) begin
            slot = (e / 4) % 4;
            chk("t3_num_b", 32'(num_b), 32'(t3_num[slot]));
            chk("t3_an_b",  32'(an_b),  32'(t3_an_b[slot]));
            chk("t3_num_n", 32'(num_n), 32'(t3_num[slot]));
            chk("t3_an_n",  32'(an_n),  32'(t3_an_n[slot]));
         end
      end

      // 4. two loads in one frame: last wins, single pulse
      do_reset();
      pulses = 0;
      for (int k = 1; k <= 31; k++) begin
         if (e == 4) begin cargar = 1'b1; valor = 16'hAAAA; end
         if (e == 8) begin cargar = 1'b1; valor = 16'hBBBB; end
         step();
         cargar = 1'b0;
         if (act_b) pulses++;
         if (e == 16) chk("t4_num0", 32'(num_b), 32'hB);
         if (e == 28) chk("t4_num3", 32'(num_b), 32'hB);
      end
      chk("t4_pulses", 32'(pulses), 32'd1);

      // 5. load held on the boundary cycle goes straight to display
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         if (e == 15) begin cargar = 1'b1; valor = 16'hC0DE; end
         step();
         cargar = 1'b0;
         if (e == 15) chk("t5_pre_act", 32'(act_b), 32'h0);
         if (e == 16) begin
            chk("t5_num", 32'(num_b), 32'hE);
            chk("t5_an",  32'(an_b),  32'hE);
            chk("t5_act", 32'(act_b), 32'h1);
         end
         if (e == 17) chk("t5_act_off", 32'(act_b), 32'h0);
         if (e == 20) begin
            chk("t5_num1", 32'(num_b), 32'hD);
            chk("t5_an1",  32'(an_b),  32'hD);
         end
      end

      // 6. reset mid-frame with a simultaneous load
      do_reset();
      for (int k = 1; k <= 21; k++) begin
         if (e == 1) begin cargar = 1'b1; valor = 16'h1234; end
         step();
         cargar = 1'b0;
      end
      chk("t6_pre_num", 32'(num_b), 32'h3);
      chk("t6_pre_an",  32'(an_b),  32'hD);
      rst = 1'b1; cargar = 1'b1; valor = 16'hFFFF;
      step();
      rst = 1'b0; cargar = 1'b0;
      chk("t6_rst_an",  32'(an_b),  32'hE);
      chk("t6_rst_num", 32'(num_b), 32'h0);
      chk("t6_rst_act", 32'(act_b), 32'h0);
      e = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         chk("t6_act", 32'(act_b), 32'h0);
         if (e == 16) begin
            chk("t6_b_an",  32'(an_b),  32'hE);
            chk("t6_b_num", 32'(num_b), 32'h0);
            chk("t6_n_num", 32'(num_n), 32'h0);
         end
         if (e == 20) chk("t6_blank_an", 32'(an_b), 32'hF);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
